// File: rtl/fta_bus_pkg.sv
// FTA bus request types shared by the mpmc11 front end.
package fta_bus_pkg;

  typedef struct packed {
    logic         cyc;
    logic         we;
    logic [3:0]   tid;
    logic [31:0]  adr;
    logic [31:0]  sel;
    logic [255:0] dat;
  } fta_cmd_request256_t;

endpackage

// File: rtl/mpmc11_pkg.sv
// Shared types and limits for the mpmc11 channel arbiter.
package mpmc11_pkg;

  localparam int MPMC11_NCH_MAX  = 16;
  localparam int MPMC11_STARVE_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_HOLD  = 2'd1,
    ARB_STALL = 2'd2
  } mpmc11_arb_state_t;

endpackage

// File: rtl/mpmc11_rr_pick.sv
// Combinational rotating priority pick: first set bit of elig at or above start, wrapping.
module mpmc11_rr_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] elig,
  input  logic [W-1:0] start,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         found
);

  always_comb begin
    int c;
    c      = 0;
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int k = 0; k < N; k++) begin
      // explicit wrap so non-power-of-two N never indexes past N-1
      c = int'(start) + k;
      if (c >= N) c = c - N;
      if (!found && elig[c]) begin
        found     = 1'b1;
        idx       = W'(c);
        onehot[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mpmc11_chan_arbiter_fta.sv
// Front-end arbiter: picks one FTA channel per cycle (starvation > hold > priority > round-robin)
// and writes the winning request with its channel id into the controller command FIFO.
module mpmc11_chan_arbiter_fta
  import fta_bus_pkg::*;
  import mpmc11_pkg::*;
#(
  parameter int NCH        = 8,
  parameter int CHW        = $clog2(NCH),
  parameter int MAX_HOLD   = 4,
  parameter int PRI_CH     = 0,
  parameter int PRI_EN     = 1,
  parameter int STARVE_LIM = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                calib_complete,
  input  logic                rst_busy,
  input  fta_cmd_request256_t req [NCH],
  input  logic [NCH-1:0]      req_v,
  output logic [NCH-1:0]      req_ack,
  input  logic                fifo_full,
  output logic                fifo_wr,
  output fta_cmd_request256_t fifo_din,
  output logic [CHW-1:0]      fifo_chan,
  output logic                busy
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int SW = MPMC11_STARVE_W;
  localparam logic [NCH-1:0] CH_ONE = {{(NCH-1){1'b0}}, 1'b1};

  mpmc11_arb_state_t   state_reg;
  logic [CHW-1:0]      rr_ptr_reg;
  logic [CHW-1:0]      hold_ch_reg;
  logic [HW-1:0]       hold_cnt_reg;
  logic [SW-1:0]       starve_reg [NCH];
  logic [NCH-1:0]      ack_reg;
  logic                wr_reg;
  fta_cmd_request256_t din_reg;
  logic [CHW-1:0]      chan_reg;

  logic [NCH-1:0] cyc_v, elig, starve_hit;
  logic           gate, pend, hold_ok, pri_ok, hold_cont;
  logic [NCH-1:0] st_oh, rr_oh, win_oh;
  logic [CHW-1:0] st_idx, rr_idx, win;
  logic           st_found, rr_found, grant;

  assign gate = calib_complete & ~rst_busy & ~fifo_full;
  // pending ignores fifo_full so a full FIFO parks us in ARB_STALL instead of ARB_IDLE
  assign pend = (|cyc_v) & calib_complete & ~rst_busy;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_elig
      assign cyc_v[gi]      = req_v[gi] & req[gi].cyc;
      assign elig[gi]       = cyc_v[gi] & gate;
      assign starve_hit[gi] = elig[gi] && (starve_reg[gi] == SW'(STARVE_LIM));
    end
  endgenerate

  mpmc11_rr_pick #(.N(NCH), .W(CHW)) u_starve_pick (
    .elig(starve_hit), .start('0), .onehot(st_oh), .idx(st_idx), .found(st_found)
  );

  mpmc11_rr_pick #(.N(NCH), .W(CHW)) u_rr_pick (
    .elig(elig), .start(rr_ptr_reg), .onehot(rr_oh), .idx(rr_idx), .found(rr_found)
  );

  assign hold_ok = (state_reg != ARB_IDLE) && elig[hold_ch_reg] &&
                   (hold_cnt_reg < HW'(MAX_HOLD));
  assign pri_ok  = (PRI_EN != 0) && elig[PRI_CH];

  always_comb begin
    grant  = 1'b0;
    win    = '0;
    win_oh = '0;
    if (st_found) begin
      grant = 1'b1; win = st_idx; win_oh = st_oh;
    end else if (hold_ok) begin
      grant = 1'b1; win = hold_ch_reg; win_oh = CH_ONE << hold_ch_reg;
    end else if (pri_ok) begin
      grant = 1'b1; win = CHW'(PRI_CH); win_oh = CH_ONE << PRI_CH;
    end else if (rr_found) begin
      grant = 1'b1; win = rr_idx; win_oh = rr_oh;
    end
  end

  assign hold_cont = (state_reg != ARB_IDLE) && (win == hold_ch_reg) &&
                     (hold_cnt_reg < HW'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ARB_IDLE;
      rr_ptr_reg   <= '0;
      hold_ch_reg  <= '0;
      hold_cnt_reg <= '0;
      ack_reg      <= '0;
      wr_reg       <= 1'b0;
      din_reg      <= '0;
      chan_reg     <= '0;
    end else begin
      ack_reg <= win_oh;
      wr_reg  <= grant;
      if (grant) begin
        din_reg      <= req[win];
        chan_reg     <= win;
        rr_ptr_reg   <= (win == CHW'(NCH - 1)) ? '0 : win + 1'b1;
        state_reg    <= ARB_HOLD;
        hold_ch_reg  <= win;
        // a channel that exhausted its hold but wins again starts a fresh run
        hold_cnt_reg <= hold_cont ? hold_cnt_reg + 1'b1 : HW'(1);
      end else if ((state_reg != ARB_IDLE) && fifo_full && pend) begin
        state_reg <= ARB_STALL;
      end else begin
        state_reg    <= ARB_IDLE;
        hold_cnt_reg <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst || !req_v[i]) begin
        starve_reg[i] <= '0;
      end else if (grant) begin
        if (win_oh[i])
          starve_reg[i] <= '0;
        else if (elig[i] && (starve_reg[i] != SW'(STARVE_LIM)))
          starve_reg[i] <= starve_reg[i] + 1'b1;
      end
    end
  end

  assign req_ack   = ack_reg;
  assign fifo_wr   = wr_reg;
  assign fifo_din  = din_reg;
  assign fifo_chan = chan_reg;
  assign busy      = (state_reg != ARB_IDLE);

endmodule

// File: tb/tb_mpmc11_chan_arbiter_fta.sv
// Directed bench: default-parameter arbiter plus a plain round-robin instance on shared inputs.
module tb_mpmc11_chan_arbiter_fta;
  import fta_bus_pkg::*;
  import mpmc11_pkg::*;

  logic clk = 1'b0;
  logic rst, calib_complete, rst_busy, fifo_full;
  fta_cmd_request256_t req [8];
  logic [7:0] req_v;

  logic [7:0] ack_a, ack_b;
  logic wr_a, wr_b, busy_a, busy_b;
  fta_cmd_request256_t din_a, din_b;
  logic [2:0] chan_a, chan_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mpmc11_chan_arbiter_fta u_dut (
    .clk(clk), .rst(rst), .calib_complete(calib_complete), .rst_busy(rst_busy),
    .req(req), .req_v(req_v), .req_ack(ack_a), .fifo_full(fifo_full),
    .fifo_wr(wr_a), .fifo_din(din_a), .fifo_chan(chan_a), .busy(busy_a)
  );

  mpmc11_chan_arbiter_fta #(.MAX_HOLD(1), .PRI_EN(0)) u_rr (
    .clk(clk), .rst(rst), .calib_complete(calib_complete), .rst_busy(rst_busy),
    .req(req), .req_v(req_v), .req_ack(ack_b), .fifo_full(fifo_full),
    .fifo_wr(wr_b), .fifo_din(din_b), .fifo_chan(chan_b), .busy(busy_b)
  );

  always @(negedge clk) begin
    if (wr_a) $display("[%0t] dut write chan=%0d adr=%h", $time, chan_a, din_a.adr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_v = 8'h00;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_oh;
    rst = 1'b1; calib_complete = 1'b1; rst_busy = 1'b0; fifo_full = 1'b0; req_v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      req[i]     = '0;
      req[i].cyc = 1'b1;
      req[i].adr = 32'h1000 + 32'(i);
      req[i].dat = {8{32'(i)}};
    end

    // reset values
    step();
    chk("rst_ack_a", 64'(ack_a), 0);
    chk("rst_wr_a", 64'(wr_a), 0);
    chk("rst_chan_a", 64'(chan_a), 0);
    chk("rst_din_a", 64'(din_a.adr), 0);
    chk("rst_busy_a", 64'(busy_a), 0);
    chk("rst_state_a", 64'(u_dut.state_reg), 64'(ARB_IDLE));
    chk("rst_ptr_a", 64'(u_dut.rr_ptr_reg), 0);
    chk("rst_wr_b", 64'(wr_b), 0);

    // calibration gating, then round-robin sweep on the plain instance
    calib_complete = 1'b0;
    rst = 1'b0;
    req_v = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("nocal_wr_a", 64'(wr_a), 0);
      chk("nocal_busy_a", 64'(busy_a), 0);
      chk("nocal_wr_b", 64'(wr_b), 0);
    end
    calib_complete = 1'b1;
    step();
    chk("cal_chan_a", 64'(chan_a), 0);
    chk("cal_ack_a", 64'(ack_a), 64'h01);
    chk("cal_busy_a", 64'(busy_a), 1);
    chk("rr_chan_b0", 64'(chan_b), 0);
    chk("rr_ack_b0", 64'(ack_b), 64'h01);
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_oh = 8'h01 << (k % 8);
      chk("rr_wr_b", 64'(wr_b), 1);
      chk("rr_chan_b", 64'(chan_b), 64'(k % 8));
      chk("rr_ack_b", 64'(ack_b), 64'(exp_oh));
      chk("rr_adr_b", 64'(din_b.adr), 64'(32'h1000 + 32'(k % 8)));
    end

    // bounded hold on channel 3, channel 5 joins with one request
    do_reset();
    req_v = 8'h08;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("hold_chan3", 64'(chan_a), 3);
      chk("hold_wr3", 64'(wr_a), 1);
    end
    req_v = 8'h28;
    step(); chk("hold_d10", 64'(chan_a), 3);
    step(); chk("hold_d11", 64'(chan_a), 3);
    chk("hold_cnt4", 64'(u_dut.hold_cnt_reg), 4);
    step(); chk("hold_ch5", 64'(chan_a), 5);
    chk("hold_ack5", 64'(ack_a), 64'h20);
    req_v = 8'h08;
    step(); chk("hold_resume3", 64'(chan_a), 3);

    // priority channel 0 versus starving channel 6
    do_reset();
    req_v = 8'h41;
    for (int k = 0; k < 15; k++) begin
      step();
      chk("pri_chan0", 64'(chan_a), 0);
    end
    chk("starve6_lim", 64'(u_dut.starve_reg[6]), 15);
    step();
    chk("starve_win6", 64'(chan_a), 6);
    chk("starve6_clr", 64'(u_dut.starve_reg[6]), 0);
    req_v = 8'h01;
    step();
    chk("pri_back0", 64'(chan_a), 0);

    // FIFO full stall while channels 1 and 2 request
    do_reset();
    req_v = 8'h06;
    step(); chk("stall_pre1", 64'(chan_a), 1);
    step(); chk("stall_pre2", 64'(chan_a), 1);
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_wr", 64'(wr_a), 0);
      chk("stall_ack", 64'(ack_a), 0);
      chk("stall_state", 64'(u_dut.state_reg), 64'(ARB_STALL));
    end
    fifo_full = 1'b0;
    step();
    chk("unstall_wr", 64'(wr_a), 1);
    chk("unstall_chan", 64'(chan_a), 1);
    chk("unstall_ack", 64'(ack_a), 64'h02);
    chk("unstall_cnt", 64'(u_dut.hold_cnt_reg), 3);
    step(); chk("unstall_ch1", 64'(chan_a), 1);
    step(); chk("unstall_ch2", 64'(chan_a), 2);
    calib_complete = 1'b0;
    step();
    chk("caldrop_wr", 64'(wr_a), 0);
    chk("caldrop_state", 64'(u_dut.state_reg), 64'(ARB_IDLE));
    calib_complete = 1'b1;

    // reset asserted mid-hold on channel 4
    do_reset();
    req_v = 8'h10;
    step(); chk("h4_chan", 64'(chan_a), 4);
    step(); chk("h4_state", 64'(u_dut.state_reg), 64'(ARB_HOLD));
    rst = 1'b1;
    step();
    chk("mrst_ack", 64'(ack_a), 0);
    chk("mrst_wr", 64'(wr_a), 0);
    chk("mrst_chan", 64'(chan_a), 0);
    chk("mrst_din", 64'(din_a.adr), 0);
    chk("mrst_busy", 64'(busy_a), 0);
    chk("mrst_state", 64'(u_dut.state_reg), 64'(ARB_IDLE));
    rst = 1'b0;
    req_v = 8'hFF;
    step(); chk("mrst_rr0", 64'(chan_b), 0);
    step(); chk("mrst_rr1", 64'(chan_b), 1);
    rst_busy = 1'b1;
    step(); chk("rstbusy_wr_a", 64'(wr_a), 0);
    chk("rstbusy_wr_b", 64'(wr_b), 0);
    rst_busy = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
